screen_sequencer: RTL

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

---
 rtl/screen_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/screen_sequencer.sv
// Frame-driven screen state machine: splash, menu, timed play round with pad scoring, results with save handshake.
// Optional attract-mode return from MENU to SPLASH is built only when SCREEN_SEQ_ATTRACT_TIMEOUT_EN is defined.
module screen_sequencer #(
    parameter int PLAY_FRAMES = 1800,
    parameter int IDLE_FRAMES = 600
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iVS,
    input  logic [31:0] controller,
    input  logic [31:0] sensor_in,
    input  logic        save_ack,
    output logic [1:0]  screen,
    output logic [5:0]  pad_level,
    output logic [7:0]  score,
    output logic        frame_tick,
    output logic        save_req,
    output logic [31:0] save_data
);

    typedef enum logic [1:0] {
        S_SPLASH  = 2'd0,
        S_MENU    = 2'd1,
        S_PLAY    = 2'd2,
        S_RESULTS = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  score_reg, score_next;
    logic [15:0] frame_cnt_reg, frame_cnt_next;
    logic [31:0] prev_btn_reg;
    logic [5:0]  pad_reg;
    logic        vs_reg;
    logic        armed_reg;
    logic        frame_tick_reg;
    logic        save_req_reg;
    logic [31:0] save_data_reg;
    logic        save_set;

    logic [5:0]  lvl;
    logic [2:0]  hit;
    logic [1:0]  ones;
    logic [8:0]  score_sum;
    logic [16:0] frame_inc;
    logic        press;

`ifdef SCREEN_SEQ_ATTRACT_TIMEOUT_EN
    localparam int IDLE_W = (IDLE_FRAMES > 1) ? $clog2(IDLE_FRAMES + 1) : 1;
    logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic [IDLE_W:0]   idle_inc;
    logic              unused_bits;
    assign unused_bits = &{1'b0, sensor_in[31:21]};
    assign idle_inc    = {1'b0, idle_cnt_reg} + {{IDLE_W{1'b0}}, 1'b1};
`else
    logic unused_bits;
    assign unused_bits = &{1'b0, sensor_in[31:21], IDLE_FRAMES[0]};
`endif

    function automatic logic [1:0] dist_to_level(input logic [6:0] d);
        logic [1:0] l;
        if (d == 7'd0)        l = 2'd0;
        else if (d < 7'd40)   l = 2'd1;
        else if (d < 7'd80)   l = 2'd2;
        else if (d < 7'd120)  l = 2'd3;
        else                  l = 2'd0;
        return l;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pad
            assign lvl[gi*2 +: 2] = dist_to_level(sensor_in[gi*7 +: 7]);
            assign hit[gi]        = (lvl[gi*2 +: 2] == 2'd1);
        end
    endgenerate

    assign ones      = {1'b0, hit[0]} + {1'b0, hit[1]} + {1'b0, hit[2]};
    assign score_sum = {1'b0, score_reg} + {7'd0, ones};
    assign frame_inc = {1'b0, frame_cnt_reg} + 17'd1;
    assign press     = (controller != 32'd0) && (prev_btn_reg == 32'd0);

    always_comb begin
        state_next     = state_reg;
        score_next     = score_reg;
        frame_cnt_next = frame_cnt_reg;
        save_set       = 1'b0;
`ifdef SCREEN_SEQ_ATTRACT_TIMEOUT_EN
        idle_cnt_next  = idle_cnt_reg;
`endif
        if (frame_tick_reg) begin
            case (state_reg)
                S_SPLASH: begin
                    if (press) state_next = S_MENU;
                end
                S_MENU: begin
`ifdef SCREEN_SEQ_ATTRACT_TIMEOUT_EN
                    idle_cnt_next = idle_inc[IDLE_W-1:0];
                    if (press) idle_cnt_next = '0;
`endif
                    if (press && (controller == 32'd2 || controller == 32'd4)) begin
                        state_next     = S_PLAY;
                        score_next     = 8'd0;
                        frame_cnt_next = 16'd0;
                    end else if (press && controller == 32'd8) begin
                        state_next = S_RESULTS;
                    end
`ifdef SCREEN_SEQ_ATTRACT_TIMEOUT_EN
                    else if (!press && idle_inc == (IDLE_W+1)'(IDLE_FRAMES)) begin
                        state_next = S_SPLASH;
                    end
`endif
                end
                S_PLAY: begin
                    score_next     = score_sum[8] ? 8'hFF : score_sum[7:0];
                    frame_cnt_next = frame_inc[15:0];
                    // Abort is checked first so it beats a timeout landing on the same frame.
                    if (press && controller == 32'd1) begin
                        state_next     = S_MENU;
                        frame_cnt_next = 16'd0;
                    end else if (frame_inc == 17'(PLAY_FRAMES)) begin
                        state_next = S_RESULTS;
                        save_set   = 1'b1;
                    end
                end
                S_RESULTS: begin
                    if (press && !save_req_reg) begin
                        state_next = S_MENU;
                        score_next = 8'd0;
                    end
                end
                default: state_next = S_SPLASH;
            endcase
        end
`ifdef SCREEN_SEQ_ATTRACT_TIMEOUT_EN
        if (state_next == S_MENU && state_reg != S_MENU) idle_cnt_next = '0;
`endif
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_reg      <= S_SPLASH;
            score_reg      <= 8'd0;
            frame_cnt_reg  <= 16'd0;
            prev_btn_reg   <= 32'd0;
            pad_reg        <= 6'd0;
            vs_reg         <= 1'b1;
            armed_reg      <= 1'b0;
            frame_tick_reg <= 1'b0;
            save_req_reg   <= 1'b0;
            save_data_reg  <= 32'd0;
`ifdef SCREEN_SEQ_ATTRACT_TIMEOUT_EN
            idle_cnt_reg   <= '0;
`endif
        end else begin
            vs_reg         <= iVS;
            // A tick needs iVS seen high since reset, so a held-low iVS at release cannot fire one.
            armed_reg      <= armed_reg | iVS;
            frame_tick_reg <= armed_reg & vs_reg & ~iVS;
            state_reg      <= state_next;
            score_reg      <= score_next;
            frame_cnt_reg  <= frame_cnt_next;
`ifdef SCREEN_SEQ_ATTRACT_TIMEOUT_EN
            idle_cnt_reg   <= idle_cnt_next;
`endif
            if (frame_tick_reg) begin
                prev_btn_reg <= controller;
                pad_reg      <= lvl;
            end
            if (save_set) begin
                save_req_reg  <= 1'b1;
                save_data_reg <= {24'd0, score_next};
            end else if (save_req_reg && save_ack) begin
                save_req_reg <= 1'b0;
            end
        end
    end

    assign screen     = state_reg;
    assign pad_level  = (state_reg == S_PLAY) ? pad_reg : 6'd0;
    assign score      = score_reg;
    assign frame_tick = frame_tick_reg;
    assign save_req   = save_req_reg;
    assign save_data  = save_data_reg;

endmodule
